// File: rtl/capture_sequencer_if.sv
// Link between the capture sequencer and the serial generator/capturer pair.
// master = sequencer side, slave = generator/capturer side.
interface capture_sequencer_if;
   logic gen_enable;
   logic strobe;
   logic data;
   logic error;

   modport master (output gen_enable, input strobe, input data, input error);
   modport slave  (input gen_enable, output strobe, output data, output error);
endinterface

// File: rtl/capture_sequencer.sv
// Capture/retry/playback sequencer for the serial lab datapath: gates the generator,
// assembles one frame from the capturer, then replays it one bit per interval.
module capture_sequencer #(
   parameter int FRAME_BITS = 16,
   parameter int INTERVAL   = 50000000,
   parameter int TIMEOUT    = 1000000,
   parameter int MAX_RETRY  = 3,
   parameter int IW         = $clog2(FRAME_BITS + 1)
) (
   input  logic                  sys_clk,
   input  logic                  sys_rst,
   input  logic                  start,
   input  logic                  print,
   capture_sequencer_if.master   link,
   output logic [2:0]            state,
   output logic                  frame_valid,
   output logic                  fault,
   output logic [FRAME_BITS-1:0] frame,
   output logic                  print_bit,
   output logic [IW-1:0]         print_idx
);

   localparam int FW = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;
   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam int CW = (INTERVAL > 1) ? $clog2(INTERVAL) : 1;
   localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

   localparam logic [IW-1:0] FRAME_END = IW'(FRAME_BITS);
   localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT - 1);
   localparam logic [CW-1:0] TICK_LAST = CW'(INTERVAL - 1);
   localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);

   typedef enum logic [2:0] {
      ST_IDLE    = 3'b000,
      ST_CAPTURE = 3'b001,
      ST_RETRY   = 3'b011,
      ST_HOLD    = 3'b010,
      ST_PLAY    = 3'b110,
      ST_FAULT   = 3'b111
   } state_t;

   state_t          state_q;
   logic            gen_enable_q;
   logic [IW-1:0]   cap_cnt;
   logic [RW-1:0]   retry_cnt;
   logic [TW-1:0]   to_cnt;
   logic [CW-1:0]   tick_cnt;

   logic            s_q, d_q, e_q, s_prev;
   logic            strobe_rise, at_term, timed_out, cap_fail, retry_ok;

   assign state           = state_q;
   assign link.gen_enable = gen_enable_q;

   // NOTE: clocked blocks use non-blocking assignments only, so every register
   // sees the pre-edge value of every other register regardless of block order.
   always_ff @(posedge sys_clk or negedge sys_rst) begin
      if (!sys_rst) begin
         s_q    <= 1'b0;
         d_q    <= 1'b0;
         e_q    <= 1'b0;
         s_prev <= 1'b0;
      end else begin
         s_q    <= link.strobe;
         d_q    <= link.data;
         e_q    <= link.error;
         s_prev <= s_q;
      end
   end

   assign strobe_rise = s_q & ~s_prev;
   assign at_term     = (cap_cnt == FRAME_END);
   assign timed_out   = ~strobe_rise & (to_cnt == TO_LAST);
   assign cap_fail    = (strobe_rise & at_term & e_q) | timed_out;
   assign retry_ok    = (retry_cnt < RETRY_MAX);

   // NOTE: frame is a flop bank rather than a RAM, so it takes the async reset
   // and no partial capture survives a reset.
   always_ff @(posedge sys_clk or negedge sys_rst) begin
      if (!sys_rst) begin
         state_q      <= ST_IDLE;
         gen_enable_q <= 1'b0;
         frame_valid  <= 1'b0;
         fault        <= 1'b0;
         frame        <= '0;
         print_bit    <= 1'b0;
         print_idx    <= '0;
         cap_cnt      <= '0;
         retry_cnt    <= '0;
         to_cnt       <= '0;
         tick_cnt     <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  state_q      <= ST_CAPTURE;
                  gen_enable_q <= 1'b1;
                  frame_valid  <= 1'b0;
                  cap_cnt      <= '0;
                  retry_cnt    <= '0;
                  to_cnt       <= '0;
               end
            end

            ST_CAPTURE: begin
               if (strobe_rise && !at_term) begin
                  frame[cap_cnt[FW-1:0]] <= d_q;
                  cap_cnt                <= cap_cnt + 1'b1;
                  to_cnt                 <= '0;
               end else if (strobe_rise && !e_q) begin
                  state_q      <= ST_HOLD;
                  gen_enable_q <= 1'b0;
                  frame_valid  <= 1'b1;
                  to_cnt       <= '0;
               end else if (cap_fail) begin
                  // Bad terminator or stalled link: recapture while budget remains.
                  gen_enable_q <= 1'b0;
                  cap_cnt      <= '0;
                  to_cnt       <= '0;
                  if (retry_ok) begin
                     state_q   <= ST_RETRY;
                     retry_cnt <= retry_cnt + 1'b1;
                  end else begin
                     state_q <= ST_FAULT;
                     fault   <= 1'b1;
                  end
               end else begin
                  to_cnt <= to_cnt + 1'b1;
               end
            end

            ST_RETRY: begin
               state_q      <= ST_CAPTURE;
               gen_enable_q <= 1'b1;
               to_cnt       <= '0;
            end

            ST_HOLD: begin
               if (print) begin
                  state_q   <= ST_PLAY;
                  tick_cnt  <= '0;
                  print_idx <= '0;
               end else if (start) begin
                  state_q      <= ST_CAPTURE;
                  gen_enable_q <= 1'b1;
                  frame_valid  <= 1'b0;
                  cap_cnt      <= '0;
                  retry_cnt    <= '0;
                  to_cnt       <= '0;
               end
            end

            ST_PLAY: begin
               if (print) begin
                  // Abort takes priority over a tick landing on the same edge.
                  state_q   <= ST_HOLD;
                  print_idx <= '0;
                  tick_cnt  <= '0;
               end else if (tick_cnt == TICK_LAST) begin
                  tick_cnt <= '0;
                  if (print_idx == FRAME_END) begin
                     state_q   <= ST_HOLD;
                     print_idx <= '0;
                  end else begin
                     print_bit <= frame[print_idx[FW-1:0]];
                     print_idx <= print_idx + 1'b1;
                  end
               end else begin
                  tick_cnt <= tick_cnt + 1'b1;
               end
            end

            ST_FAULT: begin
               if (start) begin
                  state_q      <= ST_CAPTURE;
                  gen_enable_q <= 1'b1;
                  fault        <= 1'b0;
                  cap_cnt      <= '0;
                  retry_cnt    <= '0;
                  to_cnt       <= '0;
               end
            end

            default: begin
               state_q      <= ST_IDLE;
               gen_enable_q <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_capture_sequencer.sv
// Randomized self-checking bench for capture_sequencer; expectations come from a
// frame/retry/playback model written directly from the behavioural rules.
module tb_capture_sequencer;
   localparam int FRAME_BITS = 16;
   localparam int INTERVAL   = 8;
   localparam int TIMEOUT    = 64;
   localparam int MAX_RETRY  = 3;
   localparam int IW         = $clog2(FRAME_BITS + 1);
   localparam int PLAY_LEN   = (FRAME_BITS + 1) * INTERVAL;

   localparam logic [2:0] S_IDLE    = 3'b000;
   localparam logic [2:0] S_CAPTURE = 3'b001;
   localparam logic [2:0] S_RETRY   = 3'b011;
   localparam logic [2:0] S_HOLD    = 3'b010;
   localparam logic [2:0] S_PLAY    = 3'b110;
   localparam logic [2:0] S_FAULT   = 3'b111;

   logic                  sys_clk = 1'b0;
   logic                  sys_rst = 1'b0;
   logic                  start   = 1'b0;
   logic                  print   = 1'b0;
   logic [2:0]            state;
   logic                  frame_valid, fault, print_bit;
   logic [FRAME_BITS-1:0] frame;
   logic [IW-1:0]         print_idx;

   int n_checks = 0;
   int n_fail   = 0;

   // Model state: what the frame register should hold, the last played bit, retries used.
   logic [FRAME_BITS-1:0] m_frame = '0;
   logic                  m_pb    = 1'b0;
   int                    m_retry = 0;

   capture_sequencer_if link ();

   capture_sequencer #(
      .FRAME_BITS(FRAME_BITS), .INTERVAL(INTERVAL), .TIMEOUT(TIMEOUT), .MAX_RETRY(MAX_RETRY)
   ) dut (
      .sys_clk(sys_clk), .sys_rst(sys_rst), .start(start), .print(print), .link(link),
      .state(state), .frame_valid(frame_valid), .fault(fault), .frame(frame),
      .print_bit(print_bit), .print_idx(print_idx)
   );

   always #5 sys_clk = ~sys_clk;

   // {state, gen_enable, frame_valid, fault}
   wire [5:0] flags = {state, link.gen_enable, frame_valid, fault};

   task automatic step();
      @(posedge sys_clk);
      #1;
   endtask

   task automatic send_bit(input logic b, input logic err);
      link.strobe = 1'b1; link.data = b; link.error = err;
      step();
      link.strobe = 1'b0; link.data = 1'b0; link.error = 1'b0;
      step();
   endtask

   task automatic send_frame(input logic [FRAME_BITS-1:0] w, input logic err);
      for (int i = 0; i < FRAME_BITS; i++) begin
         send_bit(w[i], 1'b0);
         m_frame[i] = w[i];
      end
      send_bit(1'b0, err);
   endtask

   task automatic pulse_start();
      start = 1'b1; step(); start = 1'b0;
   endtask

   task automatic pulse_print();
      print = 1'b1; step(); print = 1'b0;
   endtask

   task automatic test_reset();
      link.strobe = 1'b0; link.data = 1'b0; link.error = 1'b0;
      sys_rst = 1'b0;
      step(); step();
      n_checks++;
      if ({flags, frame, print_bit, print_idx} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: got flags=%b frame=%h pb=%b idx=%0d, expected all zero",
                  flags, frame, print_bit, print_idx);
      end
      sys_rst = 1'b1; step();
      pulse_print();
      send_bit(1'b1, 1'b0);
      send_bit(1'b1, 1'b0);
      n_checks++;
      if ({flags, frame} !== {S_IDLE, 3'b000, {FRAME_BITS{1'b0}}}) begin
         n_fail++;
         $display("FAIL idle_ignores: got flags=%b frame=%h, expected flags=000000 frame=0", flags, frame);
      end
   endtask

   task automatic test_good_frame();
      logic [FRAME_BITS-1:0] w = 16'hA5C3;
      pulse_start();
      n_checks++;
      if (flags !== {S_CAPTURE, 3'b100}) begin
         n_fail++;
         $display("FAIL start_capture: got flags=%b expected %b", flags, {S_CAPTURE, 3'b100});
      end
      link.strobe = 1'b1; link.data = w[0];
      step();
      n_checks++;
      if (frame[0] !== 1'b0) begin
         n_fail++;
         $display("FAIL bit_latency_early: frame[0] got %b expected 0", frame[0]);
      end
      link.strobe = 1'b0; link.data = 1'b0;
      step();
      m_frame[0] = w[0];
      n_checks++;
      if (frame[0] !== w[0]) begin
         n_fail++;
         $display("FAIL bit_latency: frame[0] got %b expected %b", frame[0], w[0]);
      end
      for (int i = 1; i < FRAME_BITS; i++) begin
         send_bit(w[i], 1'b0);
         m_frame[i] = w[i];
      end
      send_bit(1'b0, 1'b0);
      n_checks++;
      if ({flags, frame} !== {S_HOLD, 3'b010, m_frame}) begin
         n_fail++;
         $display("FAIL good_frame: got flags=%b frame=%h expected flags=%b frame=%h",
                  flags, frame, {S_HOLD, 3'b010}, m_frame);
      end
   endtask

   task automatic test_playback();
      logic [2:0]    exp_st;
      logic [IW-1:0] exp_idx;
      pulse_print();
      n_checks++;
      if ({state, print_idx} !== {S_PLAY, {IW{1'b0}}}) begin
         n_fail++;
         $display("FAIL play_enter: got state=%b idx=%0d expected state=110 idx=0", state, print_idx);
      end
      for (int c = 1; c <= PLAY_LEN; c++) begin
         step();
         if (c % INTERVAL == 0 && c / INTERVAL <= FRAME_BITS) m_pb = m_frame[c / INTERVAL - 1];
         exp_st  = (c < PLAY_LEN) ? S_PLAY : S_HOLD;
         exp_idx = (c < PLAY_LEN) ? IW'(c / INTERVAL) : '0;
         n_checks++;
         if ({state, print_idx, print_bit} !== {exp_st, exp_idx, m_pb}) begin
            n_fail++;
            $display("FAIL playback c=%0d: got state=%b idx=%0d bit=%b expected state=%b idx=%0d bit=%b",
                     c, state, print_idx, print_bit, exp_st, exp_idx, m_pb);
         end
      end
   endtask

   task automatic test_retry_fault();
      logic [5:0] exp;
      pulse_start();
      for (int a = 0; a <= MAX_RETRY; a++) begin
         send_frame(FRAME_BITS'($urandom), 1'b1);
         exp = (a < MAX_RETRY) ? {S_RETRY, 3'b000} : {S_FAULT, 3'b001};
         n_checks++;
         if ({flags, frame} !== {exp, m_frame}) begin
            n_fail++;
            $display("FAIL retry_term a=%0d: got flags=%b frame=%h expected flags=%b frame=%h",
                     a, flags, frame, exp, m_frame);
         end
         if (a < MAX_RETRY) begin
            step();
            n_checks++;
            if (flags !== {S_CAPTURE, 3'b100}) begin
               n_fail++;
               $display("FAIL retry_one_cycle a=%0d: got flags=%b expected %b", a, flags, {S_CAPTURE, 3'b100});
            end
         end
      end
      pulse_print();
      n_checks++;
      if (flags !== {S_FAULT, 3'b001}) begin
         n_fail++;
         $display("FAIL fault_ignores_print: got flags=%b expected %b", flags, {S_FAULT, 3'b001});
      end
      pulse_start();
      n_checks++;
      if (flags !== {S_CAPTURE, 3'b100}) begin
         n_fail++;
         $display("FAIL fault_release: got flags=%b expected %b", flags, {S_CAPTURE, 3'b100});
      end
      send_frame(FRAME_BITS'($urandom), 1'b1);
      n_checks++;
      if (flags !== {S_RETRY, 3'b000}) begin
         n_fail++;
         $display("FAIL retry_count_cleared: got flags=%b expected %b", flags, {S_RETRY, 3'b000});
      end
      step();
      send_frame(FRAME_BITS'($urandom), 1'b0);
      n_checks++;
      if ({flags, frame} !== {S_HOLD, 3'b010, m_frame}) begin
         n_fail++;
         $display("FAIL after_fault_good: got flags=%b frame=%h expected flags=%b frame=%h",
                  flags, frame, {S_HOLD, 3'b010}, m_frame);
      end
   endtask

   task automatic test_timeout();
      logic [FRAME_BITS-1:0] w = FRAME_BITS'($urandom);
      sys_rst = 1'b0; step(); sys_rst = 1'b1; step();
      m_frame = '0; m_pb = 1'b0;
      pulse_start();
      for (int i = 0; i < 5; i++) begin
         send_bit(w[i], 1'b0);
         m_frame[i] = w[i];
      end
      repeat (TIMEOUT - 1) step();
      n_checks++;
      if (flags !== {S_CAPTURE, 3'b100}) begin
         n_fail++;
         $display("FAIL timeout_early: got flags=%b expected %b", flags, {S_CAPTURE, 3'b100});
      end
      step();
      n_checks++;
      if ({flags, frame} !== {S_RETRY, 3'b000, m_frame}) begin
         n_fail++;
         $display("FAIL timeout_retry: got flags=%b frame=%h expected flags=%b frame=%h",
                  flags, frame, {S_RETRY, 3'b000}, m_frame);
      end
      step();
      send_frame(FRAME_BITS'($urandom), 1'b0);
      n_checks++;
      if ({flags, frame} !== {S_HOLD, 3'b010, m_frame}) begin
         n_fail++;
         $display("FAIL timeout_recapture: got flags=%b frame=%h expected flags=%b frame=%h",
                  flags, frame, {S_HOLD, 3'b010}, m_frame);
      end
   endtask

   task automatic test_abort();
      logic [2:0]    exp_st;
      logic [IW-1:0] exp_idx;
      pulse_print();
      for (int c = 1; c <= 3 * INTERVAL; c++) begin
         start = (c == 5);
         print = (c == 3 * INTERVAL);
         step();
         start = 1'b0; print = 1'b0;
         if (c % INTERVAL == 0 && c < 3 * INTERVAL) m_pb = m_frame[c / INTERVAL - 1];
         exp_st  = (c < 3 * INTERVAL) ? S_PLAY : S_HOLD;
         exp_idx = (c < 3 * INTERVAL) ? IW'(c / INTERVAL) : '0;
         n_checks++;
         if ({state, link.gen_enable, frame_valid, print_idx, print_bit} !== {exp_st, 2'b01, exp_idx, m_pb}) begin
            n_fail++;
            $display("FAIL abort c=%0d: got state=%b gen=%b valid=%b idx=%0d bit=%b expected state=%b gen=0 valid=1 idx=%0d bit=%b",
                     c, state, link.gen_enable, frame_valid, print_idx, print_bit, exp_st, exp_idx, m_pb);
         end
      end
      pulse_print();
      repeat (INTERVAL) step();
      m_pb = m_frame[0];
      n_checks++;
      if ({state, print_idx, print_bit} !== {S_PLAY, IW'(1), m_pb}) begin
         n_fail++;
         $display("FAIL replay_restart: got state=%b idx=%0d bit=%b expected state=110 idx=1 bit=%b",
                  state, print_idx, print_bit, m_pb);
      end
      pulse_print();
   endtask

   task automatic test_async_reset();
      pulse_start();
      for (int i = 0; i < 7; i++) send_bit(1'b1, 1'b0);
      #2 sys_rst = 1'b0;
      #1;
      n_checks++;
      if ({flags, frame, print_bit, print_idx} !== '0) begin
         n_fail++;
         $display("FAIL async_reset: got flags=%b frame=%h pb=%b idx=%0d expected all zero",
                  flags, frame, print_bit, print_idx);
      end
      m_frame = '0; m_pb = 1'b0;
      step();
      sys_rst = 1'b1;
      step();
      pulse_start();
      send_frame(FRAME_BITS'($urandom), 1'b0);
      n_checks++;
      if ({flags, frame} !== {S_HOLD, 3'b010, m_frame}) begin
         n_fail++;
         $display("FAIL post_reset_capture: got flags=%b frame=%h expected flags=%b frame=%h",
                  flags, frame, {S_HOLD, 3'b010}, m_frame);
      end
   endtask

   task automatic test_random();
      logic       err;
      logic [5:0] exp;
      pulse_start();
      m_retry = 0;
      for (int t = 0; t < 10; t++) begin
         err = ($urandom_range(0, 2) == 0);
         send_frame(FRAME_BITS'($urandom), err);
         if (!err)                   exp = {S_HOLD, 3'b010};
         else if (m_retry < MAX_RETRY) exp = {S_RETRY, 3'b000};
         else                        exp = {S_FAULT, 3'b001};
         n_checks++;
         if ({flags, frame} !== {exp, m_frame}) begin
            n_fail++;
            $display("FAIL random t=%0d err=%b: got flags=%b frame=%h expected flags=%b frame=%h",
                     t, err, flags, frame, exp, m_frame);
         end
         if (!err || m_retry >= MAX_RETRY) begin
            pulse_start();
            m_retry = 0;
         end else begin
            m_retry++;
            step();
         end
         n_checks++;
         if (flags !== {S_CAPTURE, 3'b100}) begin
            n_fail++;
            $display("FAIL random_recapture t=%0d: got flags=%b expected %b", t, flags, {S_CAPTURE, 3'b100});
         end
      end
   endtask

   initial begin
      test_reset();
      test_good_frame();
      test_playback();
      test_retry_fault();
      test_timeout();
      test_abort();
      test_async_reset();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
